// File: rtl/axi_read_arbiter.sv
// Two-master round-robin arbiter for one AXI read port (AR/R).
// One burst in flight; sticky flag when rlast disagrees with arlen.
module axi_read_arbiter #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [2*ADDRESS_WIDTH-1:0] m_araddr,
    input  logic [15:0]                m_arlen,
    input  logic [5:0]                 m_arsize,
    input  logic [3:0]                 m_arburst,
    input  logic [1:0]                 m_arvalid,
    output logic [1:0]                 m_arready,
    output logic [2*DATA_WIDTH-1:0]    m_rdata,
    output logic [3:0]                 m_rresp,
    output logic [1:0]                 m_rlast,
    output logic [1:0]                 m_rvalid,
    input  logic [1:0]                 m_rready,
    output logic [ADDRESS_WIDTH-1:0]   s_araddr,
    output logic [7:0]                 s_arlen,
    output logic [2:0]                 s_arsize,
    output logic [1:0]                 s_arburst,
    output logic                       s_arvalid,
    input  logic                       s_arready,
    input  logic [DATA_WIDTH-1:0]      s_rdata,
    input  logic [1:0]                 s_rresp,
    input  logic                       s_rlast,
    input  logic                       s_rvalid,
    output logic                       s_rready,
    output logic                       len_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    state_e     state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;
    logic [8:0] cnt_q, cnt_d;
    logic [7:0] len_q, len_d;
    logic       len_err_q, len_err_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 9'd0;
            len_q        <= 8'd0;
            len_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            len_err_q    <= len_err_d;
        end
    end

    // AR fields follow the registered grant; only s_arvalid qualifies them
    assign s_araddr  = grant_q ? m_araddr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                               : m_araddr[ADDRESS_WIDTH-1:0];
    assign s_arlen   = grant_q ? m_arlen[15:8]  : m_arlen[7:0];
    assign s_arsize  = grant_q ? m_arsize[5:3]  : m_arsize[2:0];
    assign s_arburst = grant_q ? m_arburst[3:2] : m_arburst[1:0];

    assign m_rdata = {2{s_rdata}};
    assign m_rresp = {2{s_rresp}};
    assign m_rlast = {2{s_rlast}};
    assign len_err = len_err_q;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        len_err_d    = len_err_q;
        s_arvalid    = 1'b0;
        m_arready    = 2'b00;
        m_rvalid     = 2'b00;
        s_rready     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|m_arvalid) begin
                    grant_d = (&m_arvalid) ? ~last_grant_q : m_arvalid[1];
                    state_d = ADDR;
                end
            end
            ADDR: begin
                s_arvalid          = m_arvalid[grant_q];
                m_arready[grant_q] = s_arready;
                if (m_arvalid[grant_q] && s_arready) begin
                    len_d   = s_arlen;
                    cnt_d   = 9'd0;
                    state_d = DATA;
                end
            end
            DATA: begin
                m_rvalid[grant_q] = s_rvalid;
                s_rready          = m_rready[grant_q];
                if (s_rvalid && m_rready[grant_q]) begin
                    // saturate so a runaway burst cannot wrap back to a match
                    if (cnt_q != 9'h1FF) cnt_d = cnt_q + 9'd1;
                    if (s_rlast) begin
                        if (cnt_q != {1'b0, len_q}) len_err_d = 1'b1;
                        last_grant_d = grant_q;
                        state_d      = IDLE;
                    end else if (cnt_q >= {1'b0, len_q}) begin
                        len_err_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Randomised bench for axi_read_arbiter: slave model, masters and a
// round-robin/beat scoreboard derived from the arbitration rules.
module tb_axi_read_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [2*AW-1:0] m_araddr = '0;
    logic [15:0]   m_arlen = '0;
    logic [5:0]    m_arsize = '0;
    logic [3:0]    m_arburst = '0;
    logic [1:0]    m_arvalid = '0;
    logic [1:0]    m_arready;
    logic [2*DW-1:0] m_rdata;
    logic [3:0]    m_rresp;
    logic [1:0]    m_rlast;
    logic [1:0]    m_rvalid;
    logic [1:0]    m_rready = 2'b11;
    logic [AW-1:0] s_araddr;
    logic [7:0]    s_arlen;
    logic [2:0]    s_arsize;
    logic [1:0]    s_arburst;
    logic          s_arvalid;
    logic          s_arready = 1'b0;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    s_rresp = '0;
    logic          s_rlast = 1'b0;
    logic          s_rvalid = 1'b0;
    logic          s_rready;
    logic          len_err;

    axi_read_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .len_err(len_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int         id;
        logic [7:0] addr;
        logic [7:0] len;
        int         adj;
    } req_t;

    req_t req0[$];
    req_t req1[$];
    req_t exp_q[$];
    int   exp_ids[$];
    int   order[$];

    int   checks = 0;
    int   errors = 0;
    int   model_last = 1;
    logic exp_err = 1'b0;
    int   bursts_done = 0;
    int   rr_mode = 0;

    logic [1:0]  ar_hs = '0;
    logic        arf = 1'b0;
    logic        rf = 1'b0;
    logic        r_active = 1'b0;
    logic        sl_busy = 1'b0;
    logic        chk_err = 1'b0;
    int          cur_id = 0;
    logic [7:0]  cur_addr = '0;
    logic [7:0]  cur_len = '0;
    int          cur_nb = 0;
    logic [15:0] cur_salt = '0;
    int          sl_idx = 0;
    int          rx = 0;

    function automatic logic [31:0] beat_data(logic [7:0] a, int i,
                                              logic [15:0] s);
        return {a, 8'(i), s};
    endfunction

    function automatic logic [1:0] beat_resp(int i, logic [15:0] s);
        return 2'(i) ^ s[1:0];
    endfunction

    // Round-robin model: both pending -> the one not served last.
    function automatic void plan();
        int   k0 = 0;
        int   k1 = 0;
        int   w;
        req_t e;
        exp_ids.delete();
        while (k0 < req0.size() || k1 < req1.size()) begin
            if (k0 < req0.size() && k1 < req1.size()) w = 1 - model_last;
            else w = (k1 < req1.size()) ? 1 : 0;
            if (w == 1) begin e = req1[k1]; k1++; end
            else begin e = req0[k0]; k0++; end
            e.id = w;
            exp_q.push_back(e);
            exp_ids.push_back(w);
            model_last = w;
        end
    endfunction

    // Monitor / scoreboard
    initial begin : mon
        logic [1:0] exp_rv;
        logic       exp_srr;
        req_t       e;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                ar_hs = '0; arf = 1'b0; rf = 1'b0; chk_err = 1'b0;
                continue;
            end
            if (chk_err) begin
                chk_err = 1'b0;
                checks++;
                if (len_err !== exp_err) begin
                    errors++;
                    $display("FAIL len_err: got %b expected %b", len_err, exp_err);
                end
            end
            ar_hs = m_arvalid & m_arready;
            arf   = s_arvalid && s_arready;
            rf    = s_rvalid && s_rready;
            exp_rv  = (r_active && s_rvalid) ? (2'b01 << cur_id) : 2'b00;
            exp_srr = r_active ? m_rready[cur_id] : 1'b0;
            checks++;
            if (m_rvalid !== exp_rv || s_rready !== exp_srr) begin
                errors++;
                $display("FAIL r_route: m_rvalid=%b s_rready=%b expected %b %b",
                         m_rvalid, s_rready, exp_rv, exp_srr);
            end
            if (arf) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ar_unexpected: addr=%h with no request", s_araddr);
                end else begin
                    e = exp_q.pop_front();
                    if (m_arready !== (2'b01 << e.id) || s_araddr !== e.addr ||
                        s_arlen !== e.len ||
                        s_arsize !== (e.id == 1 ? 3'd3 : 3'd2) ||
                        s_arburst !== (e.id == 1 ? 2'd2 : 2'd1)) begin
                        errors++;
                        $display("FAIL ar_route: arready=%b addr=%h len=%0d expected m%0d addr=%h len=%0d",
                                 m_arready, s_araddr, s_arlen, e.id, e.addr, e.len);
                    end
                    cur_id   = e.id;
                    cur_addr = e.addr;
                    cur_len  = e.len;
                    cur_nb   = int'(e.len) + 1 + e.adj;
                    cur_salt = 16'($urandom);
                    rx       = 0;
                    order.push_back(e.id);
                end
            end
            if (r_active && m_rvalid[cur_id] && m_rready[cur_id]) begin
                checks++;
                if (m_rdata[cur_id*DW +: DW] !== beat_data(cur_addr, rx, cur_salt) ||
                    m_rdata[(1-cur_id)*DW +: DW] !== beat_data(cur_addr, rx, cur_salt) ||
                    m_rresp[cur_id*2 +: 2] !== beat_resp(rx, cur_salt) ||
                    m_rlast[cur_id] !== (rx == cur_nb - 1)) begin
                    errors++;
                    $display("FAIL r_beat: m%0d beat %0d data=%h resp=%b last=%b expected %h %b %b",
                             cur_id, rx, m_rdata[cur_id*DW +: DW], m_rresp[cur_id*2 +: 2],
                             m_rlast[cur_id], beat_data(cur_addr, rx, cur_salt),
                             beat_resp(rx, cur_salt), rx == cur_nb - 1);
                end
                rx++;
            end
            if (r_active && rf && s_rlast) begin
                checks++;
                if (rx != cur_nb) begin
                    errors++;
                    $display("FAIL beat_count: got %0d expected %0d", rx, cur_nb);
                end
                if (cur_nb != int'(cur_len) + 1) exp_err = 1'b1;
                chk_err = 1'b1;
                bursts_done++;
            end
        end
    end

    // Masters and slave model, updated just after each rising edge
    initial begin : drv
        forever begin
            @(posedge aclk);
            #1;
            if (!aresetn) begin
                m_arvalid = '0; s_rvalid = 1'b0; s_rlast = 1'b0;
                s_arready = 1'b0; sl_busy = 1'b0; r_active = 1'b0;
                continue;
            end
            if (ar_hs[0] && req0.size() > 0) void'(req0.pop_front());
            if (ar_hs[1] && req1.size() > 0) void'(req1.pop_front());
            m_arvalid[0] = req0.size() > 0;
            m_arvalid[1] = req1.size() > 0;
            if (req0.size() > 0) begin
                m_araddr[7:0] = req0[0].addr; m_arlen[7:0] = req0[0].len;
                m_arsize[2:0] = 3'd2;         m_arburst[1:0] = 2'd1;
            end
            if (req1.size() > 0) begin
                m_araddr[15:8] = req1[0].addr; m_arlen[15:8] = req1[0].len;
                m_arsize[5:3]  = 3'd3;         m_arburst[3:2] = 2'd2;
            end
            if (arf) begin
                sl_busy = 1'b1; r_active = 1'b1; sl_idx = 0;
            end
            if (rf && sl_busy) begin
                sl_idx++;
                if (sl_idx == cur_nb) begin
                    sl_busy = 1'b0; r_active = 1'b0;
                end
            end
            if (!(s_rvalid && !rf)) begin
                if (sl_busy && sl_idx < cur_nb && $urandom_range(3) != 0) begin
                    s_rvalid = 1'b1;
                    s_rdata  = beat_data(cur_addr, sl_idx, cur_salt);
                    s_rresp  = beat_resp(sl_idx, cur_salt);
                    s_rlast  = (sl_idx == cur_nb - 1);
                end else begin
                    s_rvalid = 1'b0;
                    s_rlast  = 1'b0;
                    s_rdata  = $urandom;
                end
            end
            s_arready = !sl_busy && ($urandom_range(1) == 1);
            case (rr_mode)
                1:       m_rready = ~m_rready;
                2:       m_rready = 2'($urandom_range(3));
                default: m_rready = 2'b11;
            endcase
        end
    end

    function automatic req_t mk(logic [7:0] a, logic [7:0] l, int adj);
        req_t r;
        r.id = 0; r.addr = a; r.len = l; r.adj = adj;
        return r;
    endfunction

    task automatic finish_run(input int base, input int n);
        int t = 0;
        while (bursts_done < base + n && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        checks++;
        if (bursts_done < base + n) begin
            errors++;
            $display("FAIL timeout: %0d of %0d bursts completed", bursts_done - base, n);
        end
        repeat (2) @(negedge aclk);
        checks++;
        if (order != exp_ids) begin
            errors++;
            $display("FAIL grant_order: got %p expected %p", order, exp_ids);
        end
    endtask

    task automatic go();
        int base = bursts_done;
        order.delete();
        plan();
        finish_run(base, exp_ids.size());
    endtask

    task automatic do_reset();
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        checks++;
        if (s_arvalid !== 1'b0 || m_arready !== 2'b00 || m_rvalid !== 2'b00 ||
            s_rready !== 1'b0 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: arvalid=%b arready=%b rvalid=%b rready=%b len_err=%b expected all 0",
                     s_arvalid, m_arready, m_rvalid, s_rready, len_err);
        end
        req0.delete(); req1.delete(); exp_q.delete();
        r_active = 1'b0; chk_err = 1'b0; exp_err = 1'b0; model_last = 1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        #2;
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge aclk);
        #2;
        checks++;
        if (s_arvalid !== 1'b0 || m_arready !== 2'b00 || m_rvalid !== 2'b00 ||
            s_rready !== 1'b0 || len_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: arvalid=%b arready=%b rvalid=%b rready=%b len_err=%b expected all 0",
                     s_arvalid, m_arready, m_rvalid, s_rready, len_err);
        end
        @(negedge aclk);
        #2;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
    endtask

    task automatic test_single();
        int base = bursts_done;
        order.delete();
        req0.push_back(mk(8'h10, 8'd4, 0));
        plan();
        @(posedge aclk);
        #2;
        checks++;
        if (s_arvalid !== 1'b0 || m_arvalid[0] !== 1'b1) begin
            errors++;
            $display("FAIL ar_latency0: s_arvalid=%b m_arvalid=%b expected 0 1",
                     s_arvalid, m_arvalid[0]);
        end
        @(posedge aclk);
        #2;
        checks++;
        if (s_arvalid !== 1'b1 || s_araddr !== 8'h10) begin
            errors++;
            $display("FAIL ar_latency1: s_arvalid=%b addr=%h expected 1 10",
                     s_arvalid, s_araddr);
        end
        finish_run(base, 1);
    endtask

    task automatic test_both_same_cycle();
        do_reset();
        req0.push_back(mk(8'h00, 8'd3, 0));
        req1.push_back(mk(8'h40, 8'd2, 0));
        go();
    endtask

    task automatic test_back_to_back();
        req0.push_back(mk(8'h04, 8'd1, 0));
        req0.push_back(mk(8'h08, 8'd0, 0));
        req1.push_back(mk(8'h44, 8'd2, 0));
        req1.push_back(mk(8'h48, 8'd0, 0));
        go();
    endtask

    task automatic test_rready_toggle();
        rr_mode = 1;
        req0.push_back(mk(8'h20, 8'd3, 0));
        go();
        rr_mode = 0;
    endtask

    task automatic test_random();
        rr_mode = 2;
        for (int r = 0; r < 6; r++) begin
            int n0 = $urandom_range(2);
            int n1 = $urandom_range(2);
            if (n0 + n1 == 0) n0 = 1;
            for (int k = 0; k < n0; k++)
                req0.push_back(mk(8'($urandom), 8'($urandom_range(7)), 0));
            for (int k = 0; k < n1; k++)
                req1.push_back(mk(8'($urandom), 8'($urandom_range(7)), 0));
            go();
        end
        rr_mode = 0;
    endtask

    task automatic test_reset_mid();
        int t = 0;
        order.delete();
        req0.push_back(mk(8'h70, 8'd4, 0));
        plan();
        while (rx < 2 && t < 500) begin
            @(negedge aclk);
            t++;
        end
        checks++;
        if (rx < 2) begin
            errors++;
            $display("FAIL reset_mid_wait: %0d beats seen expected 2", rx);
        end
        do_reset();
        req0.push_back(mk(8'h01, 8'd1, 0));
        req1.push_back(mk(8'h41, 8'd1, 0));
        go();
    endtask

    task automatic test_len_err();
        req0.push_back(mk(8'h30, 8'd4, -2));
        go();
        req1.push_back(mk(8'h50, 8'd2, 0));
        req0.push_back(mk(8'h58, 8'd1, 0));
        go();
        req1.push_back(mk(8'h60, 8'd2, 2));
        go();
        checks++;
        if (len_err !== 1'b1) begin
            errors++;
            $display("FAIL len_err_sticky: got %b expected 1", len_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_both_same_cycle();
        test_back_to_back();
        test_rready_toggle();
        test_random();
        test_reset_mid();
        test_len_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AR/R read port of one AXI slave (e.g. axi_slave_ram) between two AXI read masters.
- Round-robin arbitration with one outstanding burst at a time.
- AR is forwarded from the granted master; R beats are routed back to that master until the last beat.
- Also checks burst length against rlast and raises a sticky error.

Parameters:
- ADDRESS_WIDTH, 8, width of araddr per master and slave.
- DATA_WIDTH, 32, width of rdata per master and slave.

Ports:
- aclk  in  1  clock; all state on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- m_araddr  in  2*ADDRESS_WIDTH  master i address at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH].
- m_arlen  in  16  master i arlen at [i*8 +: 8].
- m_arsize  in  6  master i arsize at [i*3 +: 3].
- m_arburst  in  4  master i arburst at [i*2 +: 2].
- m_arvalid  in  2  per-master AR valid.
- m_arready  out  2  per-master AR ready.
- m_rdata  out  2*DATA_WIDTH  per-master read data.
- m_rresp  out  4  per-master read response.
- m_rlast  out  2  per-master last beat.
- m_rvalid  out  2  per-master R valid.
- m_rready  in  2  per-master R ready.
- s_araddr  out  ADDRESS_WIDTH  to slave.
- s_arlen  out  8  to slave.
- s_arsize  out  3  to slave.
- s_arburst  out  2  to slave.
- s_arvalid  out  1  to slave.
- s_arready  in  1  from slave.
- s_rdata  in  DATA_WIDTH  from slave.
- s_rresp  in  2  from slave.
- s_rlast  in  1  from slave.
- s_rvalid  in  1  from slave.
- s_rready  out  1  to slave.
- len_err  out  1  sticky burst-length error.

Behaviour:
- Registered state: FSM {IDLE, ADDR, DATA}, grant (1 bit), last_grant (1 bit), beat counter (9 bits), expected length (8 bits), len_err.
- Reset (aresetn low, async): state=IDLE, grant=0, last_grant=1 (so master 0 wins first tie), counter=0, len_err=0.
- Outputs in reset and in IDLE: s_arvalid=0, m_arready=0, m_rvalid=0, s_rready=0.
- IDLE: if m_arvalid != 0, register grant:
  - only one requesting -> that one;
  - both requesting -> ~last_grant.
  - Go to ADDR next cycle. Arbitration latency is exactly 1 cycle from arvalid sampled to s_arvalid high.
- ADDR:
  - s_ar* = granted master's ar fields (combinational mux on registered grant).
  - s_arvalid = m_arvalid[grant]; m_arready[grant] = s_arready; the other m_arready = 0.
  - On s_arvalid && s_arready: latch arlen, clear counter, go to DATA.
  - Masters must hold arvalid once asserted (AXI rule); grant never changes in ADDR.
- DATA:
  - m_rvalid[grant] = s_rvalid; s_rready = m_rready[grant]; the other m_rvalid = 0.
  - m_rdata/m_rresp/m_rlast of both slots carry s_rdata/s_rresp/s_rlast unmodified; only rvalid qualifies them.
  - Each s_rvalid && s_rready beat increments the counter.
  - On a beat with s_rlast=1: if counter != latched arlen, set len_err. Then last_grant=grant, go to IDLE.
  - If counter exceeds arlen without rlast, set len_err and keep waiting for rlast.
- m_arready for the ungranted master is 0 in every state; AR requests arriving during a burst wait.
- rresp values (SLVERR etc.) are passed through with no effect on the FSM.
- Back-to-back: after a burst ends, IDLE takes at least 1 cycle, so consecutive bursts are separated by ≥2 cycles between last R beat and next s_arvalid.
- Reset mid-burst: immediate return to IDLE with all handshake outputs 0. The slave is assumed to share aresetn; no drain is performed.
- len_err clears only on reset.

Test Plan:
- Reset, then m0 requests araddr=0x10, arlen=4, arburst=1 -> s_arvalid high 1 cycle after m0 arvalid with s_araddr=0x10; 5 beats appear only on m_rvalid[0]; m_rvalid[1]=0 throughout; len_err=0.
- Both masters assert arvalid in the same cycle after reset (m0 araddr=0x00, m1 araddr=0x40) -> m0 served first, then m1 (s_araddr 0x00 then 0x40); m0 held off with arready=0 meanwhile.
- Both masters request continuously for 4 bursts -> grant order 0,1,0,1.
- m0 burst arlen=3 with m_rready[0] toggling 1,0,1,0 -> s_rready mirrors it; exactly 4 beats transferred; no beat lost or duplicated.
- aresetn pulsed low during beat 2 of a 5-beat burst -> outputs drop to 0 asynchronously; after release the next request is served from IDLE with m0 priority.
- Slave model asserts rlast on beat 3 of arlen=4 -> len_err=1, FSM returns to IDLE, len_err stays 1 across following good bursts.
